// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned INSTR_W_DEF = 60;
  localparam int unsigned OPC_W_DEF   = 4;
  localparam int unsigned ADDR_W_DEF  = 10;

  localparam int unsigned OPC_NOP_HALT = 0;
  localparam int unsigned OPC_BR_LO    = 12;
  localparam int unsigned OPC_BR_HI    = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_RESOLVE,
    S_HALT
  } fetch_state_t;

  function automatic logic is_branch_opc(input int unsigned opc);
    return (opc >= OPC_BR_LO) && (opc <= OPC_BR_HI);
  endfunction

  function automatic logic is_halt_opc(input int unsigned opc);
    return opc == OPC_NOP_HALT;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset to RESET_PC, load a redirect target, or step by one
// with wrap-around at 2^ADDR_W.
module fetch_pc_reg #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= ADDR_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: fetches words over req/ack, presents them to the
// decoder and selects the next PC. Optional FETCH_PERF_EN adds perf counters.
module instr_fetch_seq
  import fetch_pkg::*;
#(
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned OPC_W    = OPC_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  output logic [OPC_W-1:0]   opcode,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               branch_en,
  input  logic               jump_en,
  input  logic               resolve_valid,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  target_addr,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_instr_cnt,
  output logic [15:0]        perf_redirect_cnt
`endif
);

  fetch_state_t       state_q, state_d;
  logic               imem_req_q, imem_req_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               br_seen_q, br_seen_d;

  logic               pc_inc;
  logic               pc_load;
  logic [ADDR_W-1:0]  pc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .inc       (pc_inc),
    .load      (pc_load),
    .load_addr (target_addr),
    .pc        (pc)
  );

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    br_seen_d = br_seen_q;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (imem_ack) begin
          instr_d  = imem_rdata;
          opcode_d = imem_rdata[INSTR_W-1 -: OPC_W];
          pc_out_d = pc;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!stall) begin
          br_seen_d = 1'b0;
          if (is_halt_opc(32'(opcode_q))) begin
            state_d = S_HALT;
          end else if (is_branch_opc(32'(opcode_q))) begin
            state_d = S_RESOLVE;
          end else begin
            pc_inc  = 1'b1;
            state_d = S_REQ;
          end
        end
      end

      S_RESOLVE: begin
        if (branch_en) begin
          br_seen_d = 1'b1;
        end
        // Jump wins over a simultaneous branch outcome.
        if (jump_en) begin
          pc_load = 1'b1;
          state_d = S_REQ;
        end else if (resolve_valid) begin
          pc_load = branch_taken;
          pc_inc  = !branch_taken;
          state_d = S_REQ;
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with state_q.
    imem_req_d    = (state_d == S_REQ);
    instr_valid_d = (state_d == S_ISSUE);
    halted_d      = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      opcode_q      <= '0;
      instr_q       <= '0;
      pc_out_q      <= '0;
      br_seen_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      opcode_q      <= opcode_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      br_seen_q     <= br_seen_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign opcode      = opcode_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;

  // Resolution without a decoder branch_en is still obeyed; track how often.
  cov_unconfirmed_resolve: cover property (@(posedge clk)
    !rst && state_q == S_RESOLVE && !jump_en && resolve_valid && !branch_en && !br_seen_q);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_instr_q;
  logic [15:0] perf_redir_q;
  logic        issue_exit;
  logic        redirect;

  assign issue_exit = (state_q == S_ISSUE) && !stall;
  assign redirect   = (state_q == S_RESOLVE) && (jump_en || (resolve_valid && branch_taken));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_instr_q <= '0;
      perf_redir_q <= '0;
    end else begin
      if (issue_exit && perf_instr_q != '1) begin
        perf_instr_q <= perf_instr_q + 32'd1;
      end
      if (redirect && perf_redir_q != '1) begin
        perf_redir_q <= perf_redir_q + 16'd1;
      end
    end
  end

  assign perf_instr_cnt    = perf_instr_q;
  assign perf_redirect_cnt = perf_redir_q;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed scenarios plus randomized
// instruction streams checked against a PC-level reference model.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [59:0] imem_rdata;
  logic        stall;
  logic [3:0]  opcode;
  logic [59:0] instr;
  logic        instr_valid;
  logic [9:0]  pc_out;
  logic        branch_en;
  logic        jump_en;
  logic        resolve_valid;
  logic        branch_taken;
  logic [9:0]  target_addr;
  logic        halted;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [9:0]  mpc;

  always #5 clk = ~clk;

  instr_fetch_seq #(
    .INSTR_W  (60),
    .OPC_W    (4),
    .ADDR_W   (10),
    .RESET_PC (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .opcode        (opcode),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .branch_en     (branch_en),
    .jump_en       (jump_en),
    .resolve_valid (resolve_valid),
    .branch_taken  (branch_taken),
    .target_addr   (target_addr),
    .halted        (halted)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [59:0] mkw(input logic [3:0] opc);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {opc, r[55:0]};
  endfunction

  // Next fetch address from the architectural rules.
  function automatic logic [9:0] ref_next(input logic [9:0] pc, input logic [3:0] opc,
                                          input bit j, input bit tk, input logic [9:0] tgt);
    int unsigned seq;
    seq = (int'(pc) + 1) % 1024;
    if (opc >= 4'd12 && (j || tk)) return tgt;
    return seq[9:0];
  endfunction

  // Driver only: waits (bounded) for a request, then acks after 'delay' cycles.
  task automatic fetch_one(input logic [59:0] word, input int unsigned delay,
                           output logic [9:0] addr, output bit to, output int unsigned waited);
    to = 1'b1;
    addr = '0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        to = 1'b0;
        break;
      end
      step();
      waited++;
    end
    if (!to) begin
      addr = imem_addr;
      repeat (delay) step();
      stall = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = word;
      step();
      imem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 0; imem_rdata = '0; stall = 0; branch_en = 0;
    jump_en = 0; resolve_valid = 0; branch_taken = 0; target_addr = '0;
    repeat (3) step();
    total++; if ({imem_req, instr_valid, halted} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000", {imem_req, instr_valid, halted});
    end
    total++; if ({opcode, instr, pc_out} !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%0d exp=0", opcode, instr, pc_out);
    end
    rst = 1'b0;
    total++; if (imem_req !== 1'b0) begin
      bad++; $display("FAIL idle_no_req got=%b exp=0", imem_req);
    end
    mpc = 10'd0;
  endtask

  task automatic test_sequential();
    logic [3:0] opcs [3] = '{4'd1, 4'd9, 4'd5};
    logic [59:0] w; logic [9:0] a; bit to; int unsigned waited;
    for (int i = 0; i < 3; i++) begin
      w = mkw(opcs[i]);
      fetch_one(w, 0, a, to, waited);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL seq_req[%0d] got=timeout exp=req", i); end
      total++; if (a !== mpc) begin bad++; $display("FAIL seq_addr[%0d] got=%0d exp=%0d", i, a, mpc); end
      total++; if (waited !== 1) begin bad++; $display("FAIL seq_latency[%0d] got=%0d exp=1", i, waited); end
      total++; if ({instr_valid, opcode} !== {1'b1, opcs[i]}) begin
        bad++; $display("FAIL seq_opc[%0d] got=%b/%0d exp=1/%0d", i, instr_valid, opcode, opcs[i]);
      end
      total++; if (pc_out !== mpc) begin bad++; $display("FAIL seq_pcout[%0d] got=%0d exp=%0d", i, pc_out, mpc); end
      total++; if (instr !== w) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, instr, w); end
      mpc = mpc + 10'd1;
    end
  endtask

  task automatic test_stall();
    logic [59:0] w; logic [9:0] a; bit to; int unsigned waited;
    w = mkw(4'd7);
    fetch_one(w, 1, a, to, waited);
    total++; if (a !== mpc || to) begin bad++; $display("FAIL stall_addr got=%0d exp=%0d", a, mpc); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = mkw(4'd3);
      step();
      total++; if ({instr_valid, imem_req, opcode, pc_out, instr} !== {1'b1, 1'b0, 4'd7, mpc, w}) begin
        bad++; $display("FAIL stall_hold[%0d] got=v%b r%b o%0d p%0d exp=v1 r0 o7 p%0d",
                        i, instr_valid, imem_req, opcode, pc_out, mpc);
      end
    end
    imem_ack = 1'b0; stall = 1'b0;
    mpc = ref_next(mpc, 4'd7, 0, 0, '0);
    step();
    total++; if ({imem_req, imem_addr} !== {1'b1, mpc}) begin
      bad++; $display("FAIL stall_release got=%b/%0d exp=1/%0d", imem_req, imem_addr, mpc);
    end
  endtask

  // Driver only: leaves ISSUE, then applies one resolution cycle.
  task automatic resolve(input bit j, input bit rv, input bit tk, input logic [9:0] tgt);
    step();
    jump_en = j; resolve_valid = rv; branch_taken = tk; target_addr = tgt; branch_en = 1'b1;
    step();
    jump_en = 0; resolve_valid = 0; branch_taken = 0; branch_en = 0;
  endtask

  task automatic test_branch();
    logic [59:0] w; logic [9:0] a; bit to; int unsigned waited;
    fetch_one(mkw(4'd12), 0, a, to, waited);
    total++; if (a !== 10'd4 || to) begin bad++; $display("FAIL br_taken_pc got=%0d exp=4", a); end
    resolve(0, 1, 1, 10'd20);
    fetch_one(mkw(4'd13), 0, a, to, waited);
    total++; if (a !== 10'd20 || to) begin bad++; $display("FAIL br_taken_tgt got=%0d exp=20", a); end
    // Wait in RESOLVE with no outcome; nothing should be requested.
    step();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      step();
      total++; if ({imem_req, instr_valid} !== 2'b00) begin
        bad++; $display("FAIL br_wait[%0d] got=%b exp=00", i, {imem_req, instr_valid});
      end
    end
    stall = 1'b0;
    resolve_valid = 1; branch_taken = 1; target_addr = 10'd4;
    step();
    resolve_valid = 0; branch_taken = 0;
    fetch_one(mkw(4'd12), 0, a, to, waited);
    total++; if (a !== 10'd4 || to) begin bad++; $display("FAIL br_back got=%0d exp=4", a); end
    resolve(0, 1, 0, 10'd20);
    mpc = ref_next(10'd4, 4'd12, 0, 0, 10'd20);
  endtask

  task automatic test_jump_priority();
    logic [9:0] a; bit to; int unsigned waited;
    fetch_one(mkw(4'd14), 0, a, to, waited);
    total++; if (a !== mpc || to) begin bad++; $display("FAIL br_nt_next got=%0d exp=%0d", a, mpc); end
    resolve(1, 1, 0, 10'd100);
    fetch_one(mkw(4'd15), 0, a, to, waited);
    total++; if (a !== 10'd100 || to) begin bad++; $display("FAIL jump_prio got=%0d exp=100", a); end
    resolve(1, 0, 0, 10'd1023);
    mpc = 10'd1023;
  endtask

  task automatic test_wrap();
    logic [9:0] a; bit to; int unsigned waited;
    fetch_one(mkw(4'd2), 0, a, to, waited);
    total++; if (a !== 10'd1023 || to) begin bad++; $display("FAIL wrap_src got=%0d exp=1023", a); end
    mpc = ref_next(mpc, 4'd2, 0, 0, '0);
    fetch_one(mkw(4'd6), 0, a, to, waited);
    total++; if (a !== 10'd0 || to) begin bad++; $display("FAIL wrap_dst got=%0d exp=0", a); end
    mpc = ref_next(mpc, 4'd6, 0, 0, '0);
  endtask

  task automatic test_random();
    logic [59:0] w; logic [9:0] a, tgt; logic [3:0] opc; bit to, j, tk; int unsigned waited, ns;
    for (int n = 0; n < 80; n++) begin
      opc = 4'($urandom_range(1, 15));
      w = mkw(opc);
      fetch_one(w, $urandom_range(0, 3), a, to, waited);
      total++; if (to !== 1'b0 || a !== mpc) begin
        bad++; $display("FAIL rnd_addr[%0d] got=%0d to=%b exp=%0d", n, a, to, mpc);
      end
      total++; if ({instr_valid, opcode, pc_out, instr} !== {1'b1, opc, mpc, w}) begin
        bad++; $display("FAIL rnd_issue[%0d] got=v%b o%0d p%0d exp=v1 o%0d p%0d",
                        n, instr_valid, opcode, pc_out, opc, mpc);
      end
      ns = $urandom_range(0, 2);
      for (int s = 0; s < int'(ns); s++) begin
        stall = 1'b1; imem_ack = 1'($urandom); imem_rdata = mkw(4'd0);
        step();
        total++; if ({instr_valid, imem_req, opcode, instr} !== {1'b1, 1'b0, opc, w}) begin
          bad++; $display("FAIL rnd_stall[%0d] got=v%b r%b o%0d exp=v1 r0 o%0d", n, instr_valid, imem_req, opcode, opc);
        end
      end
      stall = 1'b0; imem_ack = 1'b0;
      // Redirect inputs at the ISSUE exit edge must be ignored.
      jump_en = 1'($urandom); resolve_valid = 1'($urandom); branch_taken = 1'b1;
      target_addr = 10'($urandom);
      step();
      jump_en = 0; resolve_valid = 0; branch_taken = 0;
      if (opc >= 4'd12) begin
        for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
          stall = 1'($urandom); branch_en = 1'($urandom); imem_ack = 1'($urandom);
          step();
          total++; if ({imem_req, instr_valid} !== 2'b00) begin
            bad++; $display("FAIL rnd_resolve_wait[%0d] got=%b exp=00", n, {imem_req, instr_valid});
          end
        end
        stall = 0; imem_ack = 0;
        j = ($urandom_range(0, 3) == 0); tk = 1'($urandom); tgt = 10'($urandom);
        jump_en = j; resolve_valid = j ? 1'($urandom) : 1'b1; branch_taken = tk; target_addr = tgt;
        branch_en = 1'($urandom);
        step();
        jump_en = 0; resolve_valid = 0; branch_taken = 0; branch_en = 0;
        mpc = ref_next(mpc, opc, j, tk, tgt);
      end else begin
        mpc = ref_next(mpc, opc, 0, 0, '0);
      end
    end
  endtask

  task automatic test_halt();
    logic [9:0] a; bit to; int unsigned waited;
    fetch_one(mkw(4'd0), 0, a, to, waited);
    total++; if (a !== mpc || to) begin bad++; $display("FAIL halt_addr got=%0d exp=%0d", a, mpc); end
    step();
    total++; if ({halted, instr_valid} !== 2'b10) begin
      bad++; $display("FAIL halt_enter got=%b exp=10", {halted, instr_valid});
    end
    for (int i = 0; i < 8; i++) begin
      imem_ack = 1'($urandom); jump_en = 1'($urandom); resolve_valid = 1'($urandom);
      step();
      total++; if ({imem_req, halted} !== 2'b01) begin
        bad++; $display("FAIL halt_hold[%0d] got=%b exp=01", i, {imem_req, halted});
      end
    end
    imem_ack = 0; jump_en = 0; resolve_valid = 0;
  endtask

  task automatic test_reset_midfetch();
    logic [59:0] w; logic [9:0] a; bit to; int unsigned waited;
    rst = 1'b1; step(); rst = 1'b0;
    step();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rr_req_up got=%b exp=1", imem_req); end
    #2 rst = 1'b1;
    #1;
    total++; if ({imem_req, halted} !== 2'b00) begin
      bad++; $display("FAIL rr_async got=%b exp=00", {imem_req, halted});
    end
    imem_ack = 1'b1; imem_rdata = mkw(4'd9);
    step(); step();
    rst = 1'b0;
    step();
    imem_ack = 1'b0;
    total++; if ({imem_req, imem_addr, instr_valid, opcode} !== {1'b1, 10'd0, 1'b0, 4'd0}) begin
      bad++; $display("FAIL rr_stale got=r%b a%0d v%b o%0d exp=r1 a0 v0 o0", imem_req, imem_addr, instr_valid, opcode);
    end
    w = mkw(4'd3);
    fetch_one(w, 0, a, to, waited);
    total++; if ({to, a, opcode, pc_out, instr} !== {1'b0, 10'd0, 4'd3, 10'd0, w}) begin
      bad++; $display("FAIL rr_restart got=a%0d o%0d p%0d exp=a0 o3 p0", a, opcode, pc_out);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_random();
    test_halt();
    test_reset_midfetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
